pwm_capture: RTL and testbench

- Receive-side counterpart of the team's PWM DAC output stage.
- Measures the duty cycle of a PWM pulse stream over frames of 2^N clock cycles and returns it as an N-bit digital word, one word per frame.
- Used in the mixed IIR filter loopback and test path, so the analog and feedback path can be checked digitally against the PWM transmitter's input code.
- Frames align to the transmitter's end-of-conversion strobe, or free-run when no strobe is available.

---
 rtl/pwm_capture.sv | 123 ++++++++++++
 tb/tb_pwm_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM duty-cycle capture: counts high samples over 2^N-cycle frames aligned to frame_sync.
// Optional build macro PWM_CAPTURE_DEGLITCH_EN adds a 3-tap majority filter on the pulse input.
module pwm_capture #(
  parameter int N        = 8,
  parameter bit FREE_RUN = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pulse_in,
  input  logic         frame_sync,
  output logic [N-1:0] digital_out,
  output logic         valid,
  output logic         sat,
  output logic         resync,
  output logic         locked
);

  typedef enum logic {SEEK = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [N-1:0] CYC_LAST = '1;
  localparam logic [N-1:0] CYC_ONE  = N'(1);

  logic p_meta_q, p_sync_q;
  logic fs_meta_q, fs_sync_q;
  logic s, fs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_meta_q  <= 1'b0;
      p_sync_q  <= 1'b0;
      fs_meta_q <= 1'b0;
      fs_sync_q <= 1'b0;
    end else begin
      p_meta_q  <= pulse_in;
      p_sync_q  <= p_meta_q;
      fs_meta_q <= frame_sync;
      fs_sync_q <= fs_meta_q;
    end
  end

`ifdef PWM_CAPTURE_DEGLITCH_EN
  // Majority of a clean edge tracks the middle tap, so frame_sync gets one matching stage.
  logic p_h1_q, p_h2_q, fs_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_h1_q   <= 1'b0;
      p_h2_q   <= 1'b0;
      fs_dly_q <= 1'b0;
    end else begin
      p_h1_q   <= p_sync_q;
      p_h2_q   <= p_h1_q;
      fs_dly_q <= fs_sync_q;
    end
  end

  assign s    = (p_sync_q & p_h1_q) | (p_sync_q & p_h2_q) | (p_h1_q & p_h2_q);
  assign fs_d = fs_dly_q;
`else
  assign s    = p_sync_q;
  assign fs_d = fs_sync_q;
`endif

  state_t         state_q;
  logic [N-1:0]   cyc_q;
  logic [N:0]     hi_q;
  logic [N-1:0]   dout_q;
  logic           valid_q, sat_q, resync_q, locked_q;

  logic [N:0]     total;
  logic           fs_misaligned;

  // hi_q never exceeds 2^N-1 before the last sample, so total fits in N+1 bits.
  assign total         = hi_q + {{N{1'b0}}, s};
  assign fs_misaligned = !FREE_RUN && fs_d && (cyc_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE_RUN ? MEASURE : SEEK;
      locked_q <= FREE_RUN;
      cyc_q    <= '0;
      hi_q     <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      sat_q    <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      resync_q <= 1'b0;
      if (state_q == SEEK) begin
        if (fs_d) begin
          state_q  <= MEASURE;
          locked_q <= 1'b1;
          cyc_q    <= CYC_ONE;
          hi_q     <= {{N{1'b0}}, s};
        end
      end else begin
        if (fs_misaligned) begin
          // Also covers a strobe on the last sample: that frame is dropped, not reported.
          resync_q <= 1'b1;
          cyc_q    <= CYC_ONE;
          hi_q     <= {{N{1'b0}}, s};
        end else if (cyc_q == CYC_LAST) begin
          dout_q  <= total[N] ? CYC_LAST : total[N-1:0];
          sat_q   <= total[N];
          valid_q <= 1'b1;
          cyc_q   <= '0;
          hi_q    <= '0;
        end else begin
          cyc_q <= cyc_q + CYC_ONE;
          hi_q  <= total;
        end
      end
    end
  end

  assign digital_out = dout_q;
  assign valid       = valid_q;
  assign sat         = sat_q;
  assign resync      = resync_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (N=4): aligned, free-running and glitch-filter cases.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_DEGLITCH_EN
  localparam int LAT       = 3;
  localparam int GLITCH_EXP = 5;
`else
  localparam int LAT       = 2;
  localparam int GLITCH_EXP = 6;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pulse_in = 1'b0;
  logic       frame_sync = 1'b0;
  logic [3:0] digital_out, fr_dout;
  logic       valid, sat, resync, locked;
  logic       fr_valid, fr_sat, fr_resync, fr_locked;

  pwm_capture #(.N(4), .FREE_RUN(1'b0)) dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .frame_sync(frame_sync),
    .digital_out(digital_out), .valid(valid), .sat(sat), .resync(resync), .locked(locked)
  );

  pwm_capture #(.N(4), .FREE_RUN(1'b1)) dut_fr (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .frame_sync(frame_sync),
    .digital_out(fr_dout), .valid(fr_valid), .sat(fr_sat), .resync(fr_resync), .locked(fr_locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int step_n   = 0;
  int rs_cnt   = 0;
  int rs_step  = 0;
  int fr_rs_cnt = 0;
  int v_dout[$];
  int v_sat[$];
  int v_step[$];
  int fr_step[$];
  int ev[$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic p, input logic fs);
    pulse_in   = p;
    frame_sync = fs;
    @(posedge clk);
    #1;
    step_n++;
    if (valid) begin
      v_dout.push_back(int'(digital_out));
      v_sat.push_back(int'(sat));
      v_step.push_back(step_n);
      $display("valid step %0d digital_out %0d sat %0d", step_n, digital_out, sat);
    end
    if (resync) begin
      rs_cnt++;
      rs_step = step_n;
      $display("resync step %0d", step_n);
    end
    if (fr_valid) fr_step.push_back(step_n);
    if (fr_resync) fr_rs_cnt++;
  endtask

  // One transmitter period: code_a applies to t<8, code_b to t>=8 (models a mid-frame change).
  task automatic tx_frame(input int code_a, input int code_b, input bit fs_at0,
                          input int inj_t, input int glitch_t, input int nsteps);
    for (int t = 0; t < nsteps; t++) begin
      logic p, fs;
      p  = ((t < 8) ? (t < code_a) : (t < code_b)) || (t == glitch_t);
      fs = (fs_at0 && t == 0) || (t == inj_t);
      step(p, fs);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq({tag, "_rst_dout"},   int'(digital_out), 0);
    check_eq({tag, "_rst_valid"},  int'(valid), 0);
    check_eq({tag, "_rst_sat"},    int'(sat), 0);
    check_eq({tag, "_rst_resync"}, int'(resync), 0);
    check_eq({tag, "_rst_locked"}, int'(locked), 0);
    check_eq({tag, "_rst_fr_locked"}, int'(fr_locked), 1);
    rst = 1'b0;
    step_n = 0;
    rs_cnt = 0;
    fr_rs_cnt = 0;
    v_dout.delete();
    v_sat.delete();
    v_step.delete();
    fr_step.delete();
  endtask

  task automatic check_stream(input string tag, input int first, input int exp_sat);
    check_eq({tag, "_nvalid"}, v_dout.size(), ev.size());
    for (int i = 0; i < ev.size() && i < v_dout.size(); i++) begin
      check_eq($sformatf("%s_dout%0d", tag, i), v_dout[i], ev[i]);
      check_eq($sformatf("%s_sat%0d", tag, i), v_sat[i], exp_sat);
      check_eq($sformatf("%s_step%0d", tag, i), v_step[i], first + 16 * i);
    end
  endtask

  initial begin
    // Test 1: code 5 with eoc every period.
    do_reset("t1");
    for (int f = 0; f < 6; f++) tx_frame(5, 5, 1'b1, -1, -1, 16);
    ev = '{5, 5, 5, 5, 5};
    check_stream("t1", LAT + 16, 0);
    check_eq("t1_resync_cnt", rs_cnt, 0);
    check_eq("t1_locked", int'(locked), 1);
    check_eq("t1_hold_valid", int'(valid), 0);
    check_eq("t1_hold_dout", int'(digital_out), 5);

    // Test 2a: pulse tied high, one frame_sync.
    do_reset("t2a");
    tx_frame(16, 16, 1'b1, -1, -1, 16);
    for (int f = 0; f < 3; f++) tx_frame(16, 16, 1'b0, -1, -1, 16);
    tx_frame(16, 16, 1'b0, -1, -1, 4);
    ev = '{15, 15, 15, 15};
    check_stream("t2a", LAT + 16, 1);

    // Test 2b: pulse tied low.
    do_reset("t2b");
    tx_frame(0, 0, 1'b1, -1, -1, 16);
    for (int f = 0; f < 3; f++) tx_frame(0, 0, 1'b0, -1, -1, 16);
    tx_frame(0, 0, 1'b0, -1, -1, 4);
    ev = '{0, 0, 0, 0};
    check_stream("t2b", LAT + 16, 0);

    // Test 3: code changes 3 -> 12 at t=8 of the third period: 3 + 4 = 7 transitional.
    do_reset("t3");
    tx_frame(3, 3, 1'b1, -1, -1, 16);
    tx_frame(3, 3, 1'b1, -1, -1, 16);
    tx_frame(3, 12, 1'b1, -1, -1, 16);
    for (int f = 0; f < 3; f++) tx_frame(12, 12, 1'b1, -1, -1, 16);
    tx_frame(12, 12, 1'b1, -1, -1, 4);
    ev = '{3, 3, 7, 12, 12, 12};
    check_stream("t3", LAT + 16, 0);
    check_eq("t3_resync_cnt", rs_cnt, 0);

    // Test 4: extra sync at t=7 of period 2 (step 24), eoc stopped afterwards.
    do_reset("t4");
    tx_frame(5, 5, 1'b1, -1, -1, 16);
    tx_frame(5, 5, 1'b0, 7, -1, 16);
    tx_frame(5, 5, 1'b0, -1, -1, 16);
    tx_frame(5, 5, 1'b0, -1, -1, 16);
    check_eq("t4_resync_cnt", rs_cnt, 1);
    check_eq("t4_resync_step", rs_step, 24 + LAT);
    check_eq("t4_nvalid", v_step.size(), 3);
    if (v_step.size() == 3) begin
      check_eq("t4_step0", v_step[0], LAT + 16);
      check_eq("t4_step1", v_step[1], 24 + LAT + 15);
      check_eq("t4_step2", v_step[2], 24 + LAT + 31);
      check_eq("t4_dout1", v_dout[1], 5);
      check_eq("t4_dout2", v_dout[2], 5);
    end

    // Test 5: reset mid-frame, then relock; free-running instance checked alongside.
    do_reset("t5");
    tx_frame(5, 5, 1'b1, -1, -1, 16);
    tx_frame(5, 5, 1'b1, -1, -1, 9 + LAT);
    check_eq("t5_pre_dout", int'(digital_out), 5);
    check_eq("t5_pre_locked", int'(locked), 1);
    do_reset("t5b");
    tx_frame(5, 5, 1'b0, -1, -1, 16);
    tx_frame(5, 5, 1'b0, -1, -1, 16);
    check_eq("t5_unlocked", int'(locked), 0);
    check_eq("t5_fr_locked", int'(fr_locked), 1);
    tx_frame(5, 5, 1'b1, -1, -1, 16);
    tx_frame(5, 5, 1'b0, -1, -1, 16);
    check_eq("t5_nvalid", v_step.size(), 1);
    if (v_step.size() == 1) begin
      check_eq("t5_step", v_step[0], 33 + LAT + 15);
      check_eq("t5_dout", v_dout[0], 5);
    end
    check_eq("t5_fr_nvalid", fr_step.size(), 4);
    if (fr_step.size() > 0) check_eq("t5_fr_first", fr_step[0], 16);
    check_eq("t5_fr_resync_cnt", fr_rs_cnt, 0);

    // Test 6: code 5 with a single-cycle high glitch at t=10.
    do_reset("t6");
    for (int f = 0; f < 3; f++) tx_frame(5, 5, 1'b1, -1, 10, 16);
    tx_frame(5, 5, 1'b1, -1, 10, 4);
    ev = '{GLITCH_EXP, GLITCH_EXP, GLITCH_EXP};
    check_stream("t6", LAT + 16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
